// File: rtl/div_unit_pkg.sv
// Shared CPU divider definitions: FSM state encoding, step-count limit and
// the HI/LO placement of the remainder and quotient inside the result word.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } div_state_e;

  // One restoring step per operand bit.
  function automatic int divStepLimit(input int width);
    return width;
  endfunction

  // Remainder occupies the HI (upper) half of the result.
  function automatic int divHiLsb(input int width);
    return width;
  endfunction

  // Quotient occupies the LO (lower) half of the result.
  function automatic int divLoLsb(input int width);
    return width - width;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder, trial-subtracts the divisor and keeps the difference
// only when it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_nextBit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_qBit,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH:0] w_partial;
  logic [WIDTH:0] w_trial;

  // The partial remainder is always below twice the divisor, so a
  // WIDTH+1-bit difference has its top bit set exactly when it is negative.
  assign w_partial = {i_rem, i_nextBit};
  assign w_trial   = w_partial - {1'b0, i_divisor};
  assign o_qBit    = ~w_trial[WIDTH];
  assign o_rem     = o_qBit ? w_trial[WIDTH-1:0] : w_partial[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider for the EXE stage. Produces
// {remainder, quotient} one bit per cycle; a zero divisor short-cuts to a
// zero result. The requester holds start_i until ready_o, then drops it.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW         = $clog2(WIDTH);
  localparam int STEP_LIMIT = divStepLimit(WIDTH);
  localparam int HI_LSB     = divHiLsb(WIDTH);
  localparam int LO_LSB     = divLoLsb(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEP_LIMIT - 1);

  div_state_e         r_state;
  div_state_e         w_nextState;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_quoNeg;
  logic               r_remNeg;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_abort;
  logic               w_op1Neg;
  logic               w_op2Neg;
  logic [WIDTH-1:0]   w_op1Abs;
  logic [WIDTH-1:0]   w_op2Abs;
  logic               w_qBit;
  logic [WIDTH-1:0]   w_stepRem;
  logic [WIDTH-1:0]   w_stepQuo;
  logic [WIDTH-1:0]   w_finalRem;
  logic [WIDTH-1:0]   w_finalQuo;
  logic [2*WIDTH-1:0] w_finalResult;

  assign w_accept = start_i && !annul_i;
  assign w_abort  = annul_i || !start_i;

  // Signed mode divides magnitudes; the signs are re-applied at the end.
  assign w_op1Neg = signed_div_i && opdata1_i[WIDTH-1];
  assign w_op2Neg = signed_div_i && opdata2_i[WIDTH-1];
  assign w_op1Abs = w_op1Neg ? -opdata1_i : opdata1_i;
  assign w_op2Abs = w_op2Neg ? -opdata2_i : opdata2_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_nextBit (r_quo[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_qBit    (w_qBit),
    .o_rem     (w_stepRem)
  );

  assign w_stepQuo  = {r_quo[WIDTH-2:0], w_qBit};
  assign w_finalQuo = r_quoNeg ? -w_stepQuo : w_stepQuo;
  assign w_finalRem = r_remNeg ? -w_stepRem : w_stepRem;

  // Pack the sign-corrected remainder and quotient into their HI/LO halves.
  always_comb begin
    w_finalResult = '0;
    w_finalResult[HI_LSB +: WIDTH] = w_finalRem;
    w_finalResult[LO_LSB +: WIDTH] = w_finalQuo;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= DIV_IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state logic: accept in IDLE, iterate in ON, hold in END until released.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      DIV_IDLE:   if (w_accept) w_nextState = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
      DIV_BYZERO: w_nextState = w_abort ? DIV_IDLE : DIV_END;
      DIV_ON: begin
        if (w_abort)                   w_nextState = DIV_IDLE;
        else if (r_count == LAST_STEP) w_nextState = DIV_END;
      end
      DIV_END:    if (!start_i) w_nextState = DIV_IDLE;
      default:    w_nextState = DIV_IDLE;
    endcase
  end

  // Datapath: operand capture, one shift-subtract step per cycle, result register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_quoNeg  <= 1'b0;
      r_remNeg  <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          r_result <= '0;
          if (w_accept) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= w_op1Abs;
            r_divisor <= w_op2Abs;
            r_quoNeg  <= w_op1Neg ^ w_op2Neg;
            r_remNeg  <= w_op1Neg;
          end
        end
        DIV_ON: begin
          if (w_abort) begin
            r_count  <= '0;
            r_result <= '0;
          end else begin
            r_rem   <= w_stepRem;
            r_quo   <= w_stepQuo;
            r_count <= r_count + 1'b1;
            if (r_count == LAST_STEP) r_result <= w_finalResult;
          end
        end
        DIV_BYZERO: r_result <= '0;
        DIV_END:    if (!start_i) r_result <= '0;
        default:    r_result <= '0;
      endcase
    end
  end

  assign ready_o  = (r_state == DIV_END);
  assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Randomised and directed bench for div_unit with a queue-based scoreboard.
module tb_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  int             testsRun = 0;
  int             testsFailed = 0;
  logic [2*W-1:0] expQ[$];
  logic [2*W-1:0] monExp;
  logic           prevReady = 1'b0;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; truncation to 32 bits gives the wrap case.
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on each new ready_o, and checks result_o is 0 otherwise.
  always @(negedge clk) begin
    if (ready_o && !prevReady) begin
      if (expQ.size() == 0) checkOutput("unexpectedReady", 64'(ready_o), 64'd0);
      else begin
        monExp = expQ.pop_front();
        checkOutput("scoreboardResult", result_o, monExp);
      end
    end
    if (!ready_o) checkOutput("resultZeroWhenNotReady", result_o, 64'd0);
    prevReady = ready_o;
  end

  task automatic runToReady(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            output logic [63:0] expVal);
    int  edges;
    bit  got;
    expVal = refDiv(sgn, a, b);
    expQ.push_back(expVal);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
      if (ready_o) got = 1'b1;
    end
    if (!got) checkOutput("readyTimeout", 64'(ready_o), 64'd1);
    else checkOutput("latency", 64'(edges), (b == 32'd0) ? 64'd2 : 64'd33);
  endtask

  task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] expVal;
    runToReady(sgn, a, b, expVal);
    @(posedge clk);
    #1;
    checkOutput("holdReady", 64'(ready_o), 64'd1);
    checkOutput("holdResult", result_o, expVal);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("releaseReady", 64'(ready_o), 64'd0);
    checkOutput("releaseResult", result_o, 64'd0);
  endtask

  task automatic applyAbort(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            input int steps, input bit useAnnul);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    repeat (steps + 1) @(posedge clk);
    #1;
    if (useAnnul) annul_i = 1'b1;
    else start_i = 1'b0;
    @(posedge clk);
    #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("abortNoReady", 64'(ready_o), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] expVal;
    logic [31:0] a, b;
    logic        sgn;
    int          sel;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetReady", 64'(ready_o), 64'd0);
    checkOutput("resetResult", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    applyStimulus(1'b0, 32'd100, 32'd7);
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2);
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(1'b0, 32'd5, 32'd0);
    applyStimulus(1'b1, 32'hFFFFFFFB, 32'd0);

    applyAbort(1'b0, 32'hFFFFFFFF, 32'd1, 10, 1'b1);
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1);
    applyAbort(1'b1, 32'h12345678, 32'd9, 5, 1'b0);
    applyAbort(1'b0, 32'd7, 32'd0, 0, 1'b1);

    // start_i with annul_i held in IDLE must not launch a divide.
    @(negedge clk);
    opdata1_i = 32'd50;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checkOutput("annulInIdle", 64'(ready_o), 64'd0);
    end
    start_i = 1'b0;
    annul_i = 1'b0;

    // Reset mid-divide, then a fresh divide must start cleanly.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'hDEADBEEF;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (21) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midResetReady", 64'(ready_o), 64'd0);
    checkOutput("midResetResult", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(1'b0, 32'd9, 32'd3);

    // Reset while holding a finished result must clear it at once.
    runToReady(1'b0, 32'd1000, 32'd33, expVal);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("endResetReady", 64'(ready_o), 64'd0);
    checkOutput("endResetResult", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'd1;
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      applyStimulus(sgn, a, b);
    end

    repeat (2) @(posedge clk);
    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
